// File: rtl/sdram_arb.sv
// sdram_arb: single-port arbiter between a user request stream and a periodic
// refresh generator in front of an SDRAM controller. Refresh always wins; user
// requests are accepted only when no refresh is owed.
// Optional build macro: SDRAM_ARB_STATS_EN adds stat_rd/stat_wr/stat_ref
// command counters.
module sdram_arb #(
    parameter int FREQ           = 54_000_000,
    parameter int REFRESH_CYCLES = FREQ / 1_000_000 * 15,
    parameter int DEBT_MAX       = 7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [24:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_refresh,
    output logic [24:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    input  logic        mem_data_ready,
    input  logic        mem_busy
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [15:0] stat_rd,
    output logic [15:0] stat_wr,
    output logic [15:0] stat_ref
`endif
);

    localparam logic [15:0] TICK_AT  = 16'(REFRESH_CYCLES - 1);
    localparam logic [2:0]  DEBT_LIM = 3'(DEBT_MAX);

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

    state_t      state, state_nxt;
    logic [15:0] timer;
    logic [2:0]  debt;
    logic        tick;
    logic        issue_ref;
    logic        accept;
    logic        rd_nxt, wr_nxt, ref_nxt;

    assign tick      = (timer == TICK_AT);
    assign issue_ref = (state == IDLE) & ~mem_busy & (debt != 3'd0);
    // Gated by resetn so ready stays low while reset is held even with an idle controller.
    assign req_ready = resetn & (state == IDLE) & ~mem_busy & (debt == 3'd0);
    assign accept    = req_valid & req_ready;

    // Free-running refresh interval timer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   timer <= '0;
        else if (tick) timer <= '0;
        else           timer <= timer + 16'd1;
    end

    // Owed-refresh counter: a tick and an issue in the same cycle cancel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            debt <= '0;
        end else if (tick && !issue_ref) begin
            if (debt != DEBT_LIM) debt <= debt + 3'd1;
        end else if (!tick && issue_ref) begin
            debt <= debt - 3'd1;
        end
    end

    // Next-state and command decode; refresh takes priority over user requests.
    always_comb begin
        state_nxt = state;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        ref_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (issue_ref) begin
                    ref_nxt   = 1'b1;
                    state_nxt = CMD;
                end else if (accept) begin
                    rd_nxt    = ~req_we;
                    wr_nxt    = req_we;
                    state_nxt = CMD;
                end
            end
            CMD:     state_nxt = WAIT;
            WAIT:    if (!mem_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and registered one-cycle command pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_refresh <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_rd      <= rd_nxt;
            mem_wr      <= wr_nxt;
            mem_refresh <= ref_nxt;
        end
    end

    // Address/data latched on acceptance and held until the next accepted request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (accept) begin
            mem_addr <= req_addr;
            mem_din  <= req_wdata;
        end
    end

    // Read data capture; rsp_valid trails mem_data_ready by one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= mem_data_ready;
            if (mem_data_ready) rsp_rdata <= mem_dout;
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    // Wrapping counters of issued commands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_rd  <= '0;
            stat_wr  <= '0;
            stat_ref <= '0;
        end else begin
            if (mem_rd)      stat_rd  <= stat_rd + 16'd1;
            if (mem_wr)      stat_wr  <= stat_wr + 16'd1;
            if (mem_refresh) stat_ref <= stat_ref + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: directed bench for sdram_arb with a small controller model
// (busy for 5 cycles starting 1 cycle after any command, data_ready 3 cycles
// after mem_rd).
module tb_sdram_arb;

    localparam int RC = 20;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [24:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        mem_rd, mem_wr, mem_refresh;
    logic [24:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_data_ready;
    logic        mem_busy;
`ifdef SDRAM_ARB_STATS_EN
    logic [15:0] stat_rd, stat_wr, stat_ref;
`endif

    sdram_arb #(.FREQ(54_000_000), .REFRESH_CYCLES(RC), .DEBT_MAX(7)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_data_ready(mem_data_ready), .mem_busy(mem_busy)
`ifdef SDRAM_ARB_STATS_EN
        , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_ref(stat_ref)
`endif
    );

    always #5 clk = ~clk;

    // Controller model
    logic        force_busy = 1'b1;
    logic [15:0] model_data = '0;
    logic [2:0]  busy_cnt;
    logic [1:0]  dr_cnt;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_cnt <= '0;
            dr_cnt   <= '0;
        end else begin
            if (mem_rd | mem_wr | mem_refresh) busy_cnt <= 3'd5;
            else if (busy_cnt != 0)            busy_cnt <= busy_cnt - 3'd1;
            if (mem_rd)           dr_cnt <= 2'd3;
            else if (dr_cnt != 0) dr_cnt <= dr_cnt - 2'd1;
        end
    end
    assign mem_busy       = force_busy | (busy_cnt != 0);
    assign mem_data_ready = (dr_cnt == 2'd1);
    assign mem_dout       = model_data;

    // Bus monitor: samples on the rising edge, read by the stimulus on the falling edge.
    int   cyc = 0, cnt_rd = 0, cnt_wr = 0, cnt_ref = 0, cnt_rsp = 0;
    int   last_cmd = -100, min_gap = 1000, multi_cmd = 0, ready_hits = 0, max_debt = 0;
    int   last_dr = 0, last_rsp = 0;
    logic win = 1'b0, watch_ready_low = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd | mem_wr | mem_refresh) begin
            if (win && (cyc - last_cmd < min_gap)) min_gap <= cyc - last_cmd;
            last_cmd <= cyc;
        end
        if (mem_rd)      cnt_rd  <= cnt_rd + 1;
        if (mem_wr)      cnt_wr  <= cnt_wr + 1;
        if (mem_refresh) cnt_ref <= cnt_ref + 1;
        if (int'(mem_rd) + int'(mem_wr) + int'(mem_refresh) > 1) multi_cmd <= multi_cmd + 1;
        if (rsp_valid) begin
            cnt_rsp  <= cnt_rsp + 1;
            last_rsp <= cyc;
        end
        if (mem_data_ready) last_dr <= cyc;
        if (watch_ready_low && req_ready) ready_hits <= ready_hits + 1;
        if (win && int'(dut.debt) > max_debt) max_debt <= int'(dut.debt);
    end

    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_a, snap_b, snap_c, n;

        // Reset held, controller still initialising
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_cmds", {29'd0, mem_rd, mem_wr, mem_refresh}, 32'd0);
        chk("rst_mem_addr", {7'd0, mem_addr}, 32'd0);
        chk("rst_mem_din", {16'd0, mem_din}, 32'd0);
        chk("rst_debt", {29'd0, dut.debt}, 32'd0);

        // Power-up: busy for 50 cycles after release, ticks at cycles 20 and 40
        watch_ready_low = 1'b1;
        resetn = 1'b1;
        repeat (50) @(negedge clk);
        chk("pu_debt", {29'd0, dut.debt}, 32'd2);
        chk("pu_cmds", cnt_rd + cnt_wr + cnt_ref, 32'd0);
        chk("pu_ready", ready_hits, 32'd0);
        force_busy = 1'b0;
        wait_ready("pu_wait_ready");
        watch_ready_low = 1'b0;
        chk("pu_refs_first", {31'd0, cnt_ref >= 2}, 32'd1);
        chk("pu_no_user", cnt_rd + cnt_wr, 32'd0);
        chk("pu_ready_owed", ready_hits, 32'd0);

        // Write
        wait_ready("wr_rdy");
        snap_a = cnt_rsp; snap_b = cnt_wr;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 25'h0123456; req_wdata = 16'hBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("wr_pulse", {30'd0, mem_wr, mem_rd}, 32'd2);
        chk("wr_addr", {7'd0, mem_addr}, 32'h0123456);
        chk("wr_din", {16'd0, mem_din}, 32'hBEEF);
        repeat (5) @(negedge clk);
        chk("wr_addr_hold", {7'd0, mem_addr}, 32'h0123456);
        chk("wr_din_hold", {16'd0, mem_din}, 32'hBEEF);
        wait_ready("wr_done");
        chk("wr_count", cnt_wr - snap_b, 32'd1);
        chk("wr_no_rsp", cnt_rsp - snap_a, 32'd0);

        // Read
        model_data = 16'h55AA;
        wait_ready("rd_rdy");
        snap_a = cnt_rsp; snap_b = cnt_rd;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 25'h1FFFFFF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rd_pulse", {30'd0, mem_rd, mem_wr}, 32'd2);
        chk("rd_addr", {7'd0, mem_addr}, 32'h1FFFFFF);
        repeat (6) @(negedge clk);
        chk("rd_rsp_count", cnt_rsp - snap_a, 32'd1);
        chk("rd_rdata", {16'd0, rsp_rdata}, 32'h55AA);
        chk("rd_latency", last_rsp - last_dr, 32'd1);
        chk("rd_count", cnt_rd - snap_b, 32'd1);
        model_data = 16'h0000;
        repeat (4) @(negedge clk);
        chk("rd_rdata_hold", {16'd0, rsp_rdata}, 32'h55AA);

        // Continuous request stream for 200 cycles
        wait_ready("st_rdy");
        snap_a = cnt_ref; snap_b = cnt_rd;
        win = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 25'h0000100;
        repeat (200) @(negedge clk);
        req_valid = 1'b0;
        win = 1'b0;
        chk("st_gap", {31'd0, min_gap > 6}, 32'd1);
        chk("st_debt_max", {31'd0, max_debt <= 1}, 32'd1);
        chk("st_refs", {31'd0, cnt_ref - snap_a >= 9}, 32'd1);
        chk("st_users", {31'd0, cnt_rd - snap_b >= 5}, 32'd1);
        wait_ready("st_drain");

        // Debt saturation with controller held busy
        force_busy = 1'b1;
        repeat (200) @(negedge clk);
        chk("sat_debt", {29'd0, dut.debt}, 32'd7);
        chk("sat_ready", {31'd0, req_ready}, 32'd0);
        snap_a = cnt_ref; snap_b = cnt_rd + cnt_wr; snap_c = cnt_wr;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 25'h0000ABC; req_wdata = 16'h1234;
        force_busy = 1'b0;
        n = 0;
        while (cnt_ref - snap_a < 7 && n < 150) begin
            @(negedge clk);
            n++;
        end
        chk("sat_refs", cnt_ref - snap_a, 32'd7);
        chk("sat_no_user", cnt_rd + cnt_wr - snap_b, 32'd0);
        n = 0;
        while (cnt_wr == snap_c && n < 300) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        chk("sat_user_served", cnt_wr - snap_c, 32'd1);
        chk("sat_wr_addr", {7'd0, mem_addr}, 32'h0000ABC);

        // Reset during WAIT of a read
        model_data = 16'h7777;
        wait_ready("rw_rdy");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 25'h0000555;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rw_pulse", {31'd0, mem_rd}, 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        snap_a = cnt_rsp;
        #1;
        chk("rw_cmds", {29'd0, mem_rd, mem_wr, mem_refresh}, 32'd0);
        chk("rw_addr", {7'd0, mem_addr}, 32'd0);
        chk("rw_din", {16'd0, mem_din}, 32'd0);
        chk("rw_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
        chk("rw_ready", {31'd0, req_ready}, 32'd0);
        chk("rw_debt", {29'd0, dut.debt}, 32'd0);
`ifdef SDRAM_ARB_STATS_EN
        chk("rw_stat_rd", {16'd0, stat_rd}, 32'd0);
        chk("rw_stat_wr", {16'd0, stat_wr}, 32'd0);
        chk("rw_stat_ref", {16'd0, stat_ref}, 32'd0);
`endif
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        chk("rw_no_rsp", cnt_rsp - snap_a, 32'd0);
        chk("rw_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("cmd_onehot", multi_cmd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
